mips_fwd_hazard_ctrl: RTL

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. Each cycle it drives the 2-bit forwarding selects of the EX-stage operand-A and operand-B muxes, and detects load-use hazards. On a hazard it stalls PC and IF/ID and inserts one bubble into ID/EX. It keeps its own shadow copy of the destination-register bookkeeping for EX/MEM/WB, plus a stall-cycle counter that the debug unit reads.

---
 rtl/mips_fwd_hazard_ctrl_pkg.sv | 18 +
 rtl/mips_fwd_hazard_ctrl_if.sv | 39 +++
 rtl/mips_fwd_hazard_ctrl_fwd_select.sv | 31 +++
 rtl/mips_fwd_hazard_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips_fwd_hazard_ctrl_pkg.sv
// Shared definitions for the MIPS forwarding / load-use hazard controller.
//   REG_ADDR_WIDTH : default register-file address width
//   FWD_*          : EX operand mux select codes
//   hz_state_t     : hazard FSM states
package mips_fwd_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [1:0] FWD_REG = 2'b00;  // register-file operand
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB write data
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM ALU result

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/mips_fwd_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the forwarding/hazard controller.
//   master : pipeline side, drives ID/EX status, receives selects and stall
//   slave  : controller side
//   i_enable, i_flush            pipeline advance / branch kill
//   i_valid_id, i_rs_id, i_rt_id, i_uses_rt_id   ID instruction
//   i_ex_rd, i_ex_regwrite, i_ex_memread          EX instruction
//   o_cortocircuitoA/B, o_stall, o_stall_count    controller outputs
interface mips_fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = mips_fwd_hazard_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = 32
);

  logic                      i_enable;
  logic                      i_flush;
  logic                      i_valid_id;
  logic [REG_ADDR_WIDTH-1:0] i_rs_id;
  logic [REG_ADDR_WIDTH-1:0] i_rt_id;
  logic                      i_uses_rt_id;
  logic [REG_ADDR_WIDTH-1:0] i_ex_rd;
  logic                      i_ex_regwrite;
  logic                      i_ex_memread;
  logic [1:0]                o_cortocircuitoA;
  logic [1:0]                o_cortocircuitoB;
  logic                      o_stall;
  logic [COUNT_WIDTH-1:0]    o_stall_count;

  modport master (
    output i_enable, i_flush, i_valid_id, i_rs_id, i_rt_id, i_uses_rt_id,
           i_ex_rd, i_ex_regwrite, i_ex_memread,
    input  o_cortocircuitoA, o_cortocircuitoB, o_stall, o_stall_count
  );

  modport slave (
    input  i_enable, i_flush, i_valid_id, i_rs_id, i_rt_id, i_uses_rt_id,
           i_ex_rd, i_ex_regwrite, i_ex_memread,
    output o_cortocircuitoA, o_cortocircuitoB, o_stall, o_stall_count
  );

endinterface

// File: rtl/mips_fwd_hazard_ctrl_fwd_select.sv
// mips_fwd_select: combinational forwarding select for one EX operand.
//   ex_valid      EX holds a real instruction
//   src           source register read by the EX instruction
//   mem_rd/mem_regwrite  MEM-stage destination (caller masks out loads)
//   wb_rd/wb_regwrite    WB-stage destination
//   sel           FWD_MEM / FWD_WB / FWD_REG, MEM taking priority
module mips_fwd_select #(
  parameter int REG_ADDR_WIDTH = mips_fwd_hazard_ctrl_pkg::REG_ADDR_WIDTH
) (
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_regwrite,
  output logic [1:0]                sel
);
  import mips_fwd_hazard_ctrl_pkg::*;

  always_comb begin
    sel = FWD_REG;
    if (ex_valid) begin
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/mips_fwd_hazard_ctrl.sv
// mips_fwd_hazard_ctrl: EX operand forwarding and load-use stall control.
//   i_clock, i_reset : clock, synchronous active-high reset
//   bus (slave)      : ID/EX status in; forwarding selects, stall and
//                      saturating stall-cycle counter out
// Keeps a shadow of EX/MEM/WB destination bookkeeping; a load-use hazard
// stalls exactly one cycle, after which the load sits in WB and the
// consumer picks its data up through the WB forward path.
module mips_fwd_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = mips_fwd_hazard_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  mips_fwd_hazard_ctrl_if.slave  bus
);
  import mips_fwd_hazard_ctrl_pkg::*;

  hz_state_t                 state;
  hz_state_t                 state_nxt;
  logic                      hazard;

  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_regwrite;
  logic                      mem_memread;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic                      wb_regwrite;
  logic                      mem_fwd_ok;
  logic [COUNT_WIDTH-1:0]    stall_count;

  // Hazard detection and next state; the cycle after a stall the
  // dependent is still in ID but must not re-trigger.
  always_comb begin
    hazard    = 1'b0;
    state_nxt = state;
    if (state == ST_RUN) begin
      hazard = bus.i_valid_id && ex_valid && bus.i_ex_memread &&
               (bus.i_ex_rd != '0) &&
               ((bus.i_ex_rd == bus.i_rs_id) ||
                (bus.i_uses_rt_id && (bus.i_ex_rd == bus.i_rt_id))) &&
               !bus.i_flush;
    end
    if (bus.i_enable) begin
      case (state)
        ST_RUN:   if (hazard) state_nxt = ST_STALL;
        ST_STALL: state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (bus.i_enable) begin
      mem_rd       <= bus.i_ex_rd;
      mem_regwrite <= bus.i_ex_regwrite && ex_valid;
      mem_memread  <= bus.i_ex_memread && ex_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      if (hazard || bus.i_flush) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= bus.i_valid_id;
        ex_rs    <= bus.i_rs_id;
        ex_rt    <= bus.i_rt_id;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_count <= '0;
    end else if (bus.i_enable && hazard && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Load data is not available in MEM, so a load there is never a source.
  assign mem_fwd_ok = mem_regwrite && !mem_memread;

  mips_fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .ex_valid     (ex_valid),
    .src          (ex_rs),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_fwd_ok),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (bus.o_cortocircuitoA)
  );

  mips_fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .ex_valid     (ex_valid),
    .src          (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_fwd_ok),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (bus.o_cortocircuitoB)
  );

  assign bus.o_stall       = hazard;
  assign bus.o_stall_count = stall_count;

endmodule
